// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris playfield engine.
package tetris_pkg;

   typedef enum logic [2:0] {
      IDLE, SPAWN, FALL, DROP, LOCK, CLEAR, SCORE, GAMEOVER
   } state_t;

   typedef enum logic [2:0] {
      PIECE_I, PIECE_O, PIECE_J, PIECE_L, PIECE_S, PIECE_Z, PIECE_T
   } piece_t;

   // Points awarded for 0..4 lines cleared by a single lock.
   localparam logic [4:0][3:0] SCORE_WEIGHT = {4'd8, 4'd5, 4'd3, 4'd1, 4'd0};

endpackage

// File: rtl/tetromino_rom.sv
// Tetromino shape table: (piece, rotation) -> 4x4 mask, bit index = row*4 + col.
module tetromino_rom
   import tetris_pkg::*;
(
   input  logic [2:0]  piece,
   input  logic [1:0]  rot,
   output logic [15:0] mask
);

   logic [3:0][15:0] tbl;

   // Entry 0 is rotation 0; each step is a clockwise turn inside the bounding box.
   always_comb begin
      tbl = '0;
      case (piece)
         PIECE_I: tbl = {16'h2222, 16'h0F00, 16'h4444, 16'h00F0};
         PIECE_O: tbl = {16'h0066, 16'h0066, 16'h0066, 16'h0066};
         PIECE_J: tbl = {16'h0322, 16'h0470, 16'h0226, 16'h0071};
         PIECE_L: tbl = {16'h0223, 16'h0170, 16'h0622, 16'h0074};
         PIECE_S: tbl = {16'h0231, 16'h0360, 16'h0462, 16'h0036};
         PIECE_Z: tbl = {16'h0132, 16'h0630, 16'h0264, 16'h0063};
         PIECE_T: tbl = {16'h0232, 16'h0270, 16'h0262, 16'h0072};
         default: tbl = '0;
      endcase
      mask = tbl[rot];
   end

endmodule

// File: rtl/tetris_grid_engine.sv
// Tetris playfield engine: locked board, one active piece, collision checks,
// line clearing and saturating score. Row 0 of the board is the top.
//
// state    | meaning
// IDLE     | after reset, waiting for start_i
// SPAWN    | request and latch next piece; game over if it does not fit
// FALL     | piece under player control and gravity
// DROP     | hard drop in progress, one row per cycle
// LOCK     | merge active piece into the board
// CLEAR    | scan rows bottom-up, collapse full rows
// SCORE    | add weighted score and line count
// GAMEOVER | board and score frozen until start_i
module tetris_grid_engine
   import tetris_pkg::*;
#(
   parameter int ROWS    = 20,
   parameter int COLS    = 10,
   parameter int SCORE_W = 16,
   parameter int LINES_W = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick_i,
   input  logic                   start_i,
   input  logic                   left_i,
   input  logic                   right_i,
   input  logic                   rotate_i,
   input  logic                   drop_i,
   input  logic [2:0]             piece_i,
   output logic                   piece_req_o,
   output logic [ROWS*COLS-1:0]   display_o,
   output logic                   gameover_o,
   output logic [SCORE_W-1:0]     score_o,
   output logic [LINES_W-1:0]     lines_o
);

   localparam int XW = $clog2(COLS) + 2;
   localparam int YW = $clog2(ROWS) + 1;
   localparam int RB = $clog2(ROWS);
   localparam int CB = $clog2(COLS);
   localparam logic signed [XW-1:0] SPAWN_X = XW'((COLS - 4) / 2);

   typedef logic [ROWS-1:0][COLS-1:0] board_t;

   state_t                state;
   board_t                board;
   board_t                act;
   board_t                disp;
   logic [2:0]            p_type;
   logic [1:0]            p_rot;
   logic signed [XW-1:0]  p_x;
   logic [YW-1:0]         p_y;
   logic                  pend;
   logic [RB-1:0]         eval_row;
   logic [2:0]            clr_cnt;
   logic [SCORE_W-1:0]    score;
   logic [LINES_W-1:0]    lines;

   logic [15:0]           cur_mask, rot_mask, spawn_mask;
   logic                  fit_rot, fit_left, fit_right, fit_down, fit_spawn;
   logic                  row_full;
   logic [SCORE_W:0]      score_sum;
   logic [LINES_W:0]      lines_sum;

   tetromino_rom u_rom_cur   (.piece(p_type),  .rot(p_rot),         .mask(cur_mask));
   tetromino_rom u_rom_rot   (.piece(p_type),  .rot(p_rot + 2'd1),  .mask(rot_mask));
   tetromino_rom u_rom_spawn (.piece(piece_i), .rot(2'd0),          .mask(spawn_mask));

   function automatic logic fits(input logic [15:0] m, input int px, input int py,
                                 input board_t b);
      fits = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (m[4'(4*r + c)]) begin
               if ((px + c) < 0 || (px + c) >= COLS || (py + r) >= ROWS)
                  fits = 1'b0;
               else if (b[RB'(py + r)][CB'(px + c)])
                  fits = 1'b0;
            end
         end
      end
   endfunction

   always_comb begin
      fit_rot   = fits(rot_mask,   int'(p_x),     int'(p_y),     board);
      fit_left  = fits(cur_mask,   int'(p_x) - 1, int'(p_y),     board);
      fit_right = fits(cur_mask,   int'(p_x) + 1, int'(p_y),     board);
      fit_down  = fits(cur_mask,   int'(p_x),     int'(p_y) + 1, board);
      fit_spawn = fits(spawn_mask, int'(SPAWN_X), 0,             board);
   end

   always_comb begin
      act = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (cur_mask[4'(4*r + c)] && (int'(p_x) + c) >= 0 && (int'(p_x) + c) < COLS
                && (int'(p_y) + r) < ROWS)
               act[RB'(int'(p_y) + r)][CB'(int'(p_x) + c)] = 1'b1;
         end
      end
      disp = (state == FALL || state == DROP) ? (board | act) : board;
   end

   assign row_full  = &board[eval_row];
   assign score_sum = {1'b0, score} + (SCORE_W+1)'(SCORE_WEIGHT[clr_cnt]);
   assign lines_sum = {1'b0, lines} + (LINES_W+1)'(clr_cnt);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         board    <= '0;
         score    <= '0;
         lines    <= '0;
         pend     <= 1'b0;
         p_type   <= '0;
         p_rot    <= '0;
         p_x      <= '0;
         p_y      <= '0;
         eval_row <= '0;
         clr_cnt  <= '0;
      end else begin
         case (state)
            IDLE: if (start_i) state <= SPAWN;
            SPAWN: begin
               p_type <= piece_i;
               p_rot  <= 2'd0;
               p_x    <= SPAWN_X;
               p_y    <= '0;
               pend   <= 1'b0;
               state  <= fit_spawn ? FALL : GAMEOVER;
            end
            FALL: begin
               // A losing tick is remembered so gravity is never lost to input traffic.
               if (drop_i) begin
                  state <= DROP;
                  pend  <= pend | tick_i;
               end else if (rotate_i) begin
                  if (fit_rot) p_rot <= p_rot + 2'd1;
                  pend <= pend | tick_i;
               end else if (left_i) begin
                  if (fit_left) p_x <= p_x - XW'(1);
                  pend <= pend | tick_i;
               end else if (right_i) begin
                  if (fit_right) p_x <= p_x + XW'(1);
                  pend <= pend | tick_i;
               end else if (tick_i || pend) begin
                  pend <= 1'b0;
                  if (fit_down) p_y <= p_y + 1'b1;
                  else          state <= LOCK;
               end
            end
            DROP: begin
               if (fit_down) p_y <= p_y + 1'b1;
               else          state <= LOCK;
            end
            LOCK: begin
               board    <= board | act;
               eval_row <= RB'(ROWS - 1);
               clr_cnt  <= '0;
               state    <= CLEAR;
            end
            CLEAR: begin
               // Same row is re-evaluated after a collapse so stacked full rows cascade.
               if (row_full) begin
                  for (int i = 1; i < ROWS; i++)
                     if (i <= int'(eval_row)) board[i] <= board[i-1];
                  board[0] <= '0;
                  clr_cnt  <= clr_cnt + 3'd1;
               end else if (eval_row == '0) begin
                  state <= SCORE;
               end else begin
                  eval_row <= eval_row - 1'b1;
               end
            end
            SCORE: begin
               score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
               lines <= lines_sum[LINES_W] ? '1 : lines_sum[LINES_W-1:0];
               state <= SPAWN;
            end
            GAMEOVER: begin
               if (start_i) begin
                  board <= '0;
                  score <= '0;
                  lines <= '0;
                  state <= SPAWN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign piece_req_o = (state == SPAWN);
   assign gameover_o  = (state == GAMEOVER);
   assign display_o   = disp;
   assign score_o     = score;
   assign lines_o     = lines;

endmodule

// File: tb/tb_tetris_grid_engine.sv
// Bench for tetris_grid_engine: directed vectors plus random play against a cell-list model.
module tb_tetris_grid_engine;

   localparam int ROWS = 20, COLS = 10, SCORE_W = 16, LINES_W = 10;
   localparam int N = ROWS * COLS;
   localparam int SPX = (COLS - 4) / 2;

   logic clk = 1'b0, reset = 1'b0;
   logic tick_i = 0, start_i = 0, left_i = 0, right_i = 0, rotate_i = 0, drop_i = 0;
   logic [2:0] piece_i = 3'd0;
   logic piece_req_o, gameover_o;
   logic [N-1:0] display_o;
   logic [SCORE_W-1:0] score_o;
   logic [LINES_W-1:0] lines_o;

   tetris_grid_engine #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W), .LINES_W(LINES_W)) dut (
      .clk(clk), .reset(reset), .tick_i(tick_i), .start_i(start_i), .left_i(left_i),
      .right_i(right_i), .rotate_i(rotate_i), .drop_i(drop_i), .piece_i(piece_i),
      .piece_req_o(piece_req_o), .display_o(display_o), .gameover_o(gameover_o),
      .score_o(score_o), .lines_o(lines_o));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   bit brd[ROWS][COLS];
   int pt, pr, px, py, m_score, m_lines;
   bit pend, m_go;

   typedef struct {
      bit l, r, rt, t;
      int r0, r1;
      logic [COLS-1:0] cm;
   } vec_t;
   vec_t vecs[12];

   task automatic chk_int(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_disp(input string name, input logic [N-1:0] exp);
      checks++;
      if (display_o !== exp) begin
         errors++;
         $display("FAIL %s: display got %h expected %h", name, display_o, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      tick_i = 0; start_i = 0; left_i = 0; right_i = 0; rotate_i = 0; drop_i = 0;
   endtask

   // Cells of a piece from its spawn-orientation cell list, rotated clockwise in its box.
   function automatic void shape(input int t, input int rot, output int rr[4], output int cc[4]);
      int n, tmp;
      case (t)
         0: begin rr = '{1,1,1,1}; cc = '{0,1,2,3}; n = 4; end
         1: begin rr = '{0,0,1,1}; cc = '{1,2,1,2}; n = 0; end
         2: begin rr = '{0,1,1,1}; cc = '{0,0,1,2}; n = 3; end
         3: begin rr = '{0,1,1,1}; cc = '{2,0,1,2}; n = 3; end
         4: begin rr = '{0,0,1,1}; cc = '{1,2,0,1}; n = 3; end
         5: begin rr = '{0,0,1,1}; cc = '{0,1,1,2}; n = 3; end
         default: begin rr = '{0,1,1,1}; cc = '{1,0,1,2}; n = 3; end
      endcase
      if (n > 0)
         for (int k = 0; k < rot; k++)
            for (int j = 0; j < 4; j++) begin
               tmp = rr[j]; rr[j] = cc[j]; cc[j] = n - 1 - tmp;
            end
   endfunction

   function automatic bit m_fits(input int t, input int rot, input int x, input int y);
      int rr[4], cc[4];
      shape(t, rot, rr, cc);
      for (int k = 0; k < 4; k++) begin
         if (x + cc[k] < 0 || x + cc[k] >= COLS || y + rr[k] >= ROWS) return 0;
         if (brd[y + rr[k]][x + cc[k]]) return 0;
      end
      return 1;
   endfunction

   function automatic logic [N-1:0] m_disp(input bit with_act);
      logic [N-1:0] d;
      int rr[4], cc[4];
      d = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (brd[r][c]) d[r*COLS + c] = 1'b1;
      if (with_act) begin
         shape(pt, pr, rr, cc);
         for (int k = 0; k < 4; k++) d[(py + rr[k])*COLS + px + cc[k]] = 1'b1;
      end
      return d;
   endfunction

   function automatic logic [N-1:0] rows_mask(input int r0, input int r1, input logic [COLS-1:0] cm);
      logic [N-1:0] d;
      d = '0;
      for (int r = r0; r <= r1; r++)
         for (int c = 0; c < COLS; c++)
            if (cm[c]) d[r*COLS + c] = 1'b1;
      return d;
   endfunction

   task automatic m_reset();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) brd[r][c] = 0;
      m_score = 0; m_lines = 0; m_go = 0; pend = 0;
   endtask

   // Lock the piece, compact away full rows, and award weighted score.
   task automatic m_lock();
      int rr[4], cc[4];
      int w[5] = '{0, 1, 3, 5, 8};
      bit nb[ROWS][COLS];
      int n, dst;
      bit full;
      shape(pt, pr, rr, cc);
      for (int k = 0; k < 4; k++) brd[py + rr[k]][px + cc[k]] = 1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) nb[r][c] = 0;
      n = 0; dst = ROWS - 1;
      for (int r = ROWS - 1; r >= 0; r--) begin
         full = 1;
         for (int c = 0; c < COLS; c++) if (!brd[r][c]) full = 0;
         if (full) n++;
         else begin nb[dst] = brd[r]; dst--; end
      end
      brd = nb;
      m_score = m_score + w[n];
      if (m_score > (1 << SCORE_W) - 1) m_score = (1 << SCORE_W) - 1;
      m_lines = m_lines + n;
      if (m_lines > (1 << LINES_W) - 1) m_lines = (1 << LINES_W) - 1;
   endtask

   task automatic wait_spawn(output int n);
      n = 0;
      while (piece_req_o !== 1'b1 && n < 400) begin
         left_i = 1'($urandom_range(0, 1));
         right_i = 1'($urandom_range(0, 1));
         rotate_i = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      chk_int("spawn_reached", piece_req_o, 1);
      chk_disp("board_after_lock", m_disp(0));
      chk_int("score", score_o, m_score);
      chk_int("lines", lines_o, m_lines);
   endtask

   task automatic spawn_piece(input int pc);
      piece_i = 3'(pc);
      step();
      if (m_fits(pc, 0, SPX, 0)) begin
         pt = pc; pr = 0; px = SPX; py = 0; pend = 0; m_go = 0;
      end else m_go = 1;
      chk_int("req_pulse_end", piece_req_o, 0);
      chk_int("gameover", gameover_o, m_go);
      chk_disp("spawn_disp", m_disp(!m_go));
   endtask

   task automatic restart(input int pc);
      start_i = 1;
      step();
      m_reset();
      chk_int("start_req", piece_req_o, 1);
      chk_disp("start_board", '0);
      chk_int("start_score", score_o, 0);
      chk_int("start_lines", lines_o, 0);
      chk_int("start_gameover", gameover_o, 0);
      spawn_piece(pc);
   endtask

   task automatic fall_cmd(input bit d, input bit rt, input bit l, input bit r, input bit t,
                           input string name, output bit locked, output int nwait);
      drop_i = d; rotate_i = rt; left_i = l; right_i = r; tick_i = t;
      step();
      locked = 0; nwait = 0;
      if (d) begin
         while (m_fits(pt, pr, px, py + 1)) py++;
         m_lock(); locked = 1;
      end else if (rt) begin
         if (m_fits(pt, (pr + 1) % 4, px, py)) pr = (pr + 1) % 4;
         if (t) pend = 1;
      end else if (l) begin
         if (m_fits(pt, pr, px - 1, py)) px--;
         if (t) pend = 1;
      end else if (r) begin
         if (m_fits(pt, pr, px + 1, py)) px++;
         if (t) pend = 1;
      end else if (t || pend) begin
         pend = 0;
         if (m_fits(pt, pr, px, py + 1)) py++;
         else begin m_lock(); locked = 1; end
      end
      if (locked) wait_spawn(nwait);
      else chk_disp(name, m_disp(1));
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit lk;
      int nw;
      logic [N-1:0] o_floor;

      vecs[0]  = '{1,0,0,0, 1,1, 10'b0000111100};
      vecs[1]  = '{1,0,0,0, 1,1, 10'b0000011110};
      vecs[2]  = '{1,0,0,0, 1,1, 10'b0000001111};
      vecs[3]  = '{1,0,0,0, 1,1, 10'b0000001111};
      vecs[4]  = '{0,0,1,0, 0,3, 10'b0000000100};
      vecs[5]  = '{0,1,0,0, 0,3, 10'b0000001000};
      vecs[6]  = '{0,0,0,1, 1,4, 10'b0000001000};
      vecs[7]  = '{1,0,0,1, 1,4, 10'b0000000100};
      vecs[8]  = '{0,0,0,0, 2,5, 10'b0000000100};
      vecs[9]  = '{0,0,1,0, 4,4, 10'b0000001111};
      vecs[10] = '{0,1,0,0, 4,4, 10'b0000011110};
      vecs[11] = '{0,0,1,0, 2,5, 10'b0000000100};

      m_reset();
      reset = 0;
      repeat (3) step();
      chk_disp("reset_disp", '0);
      chk_int("reset_score", score_o, 0);
      chk_int("reset_lines", lines_o, 0);
      chk_int("reset_gameover", gameover_o, 0);
      chk_int("reset_req", piece_req_o, 0);
      reset = 1;
      step();
      chk_int("idle_no_req", piece_req_o, 0);

      // O spawn, hard drop to the floor with exact latency, then an I piece.
      restart(1);
      chk_disp("spawn_O_cells", rows_mask(0, 1, 10'b0000110000));
      piece_i = 3'd0;
      fall_cmd(1, 0, 0, 0, 0, "drop_O", lk, nw);
      chk_int("drop_latency", nw + 1, 42);
      o_floor = rows_mask(18, 19, 10'b0000110000);
      chk_disp("O_landed", o_floor);
      spawn_piece(0);
      chk_disp("spawn_I_cells", rows_mask(1, 1, 10'b0001111000) | o_floor);

      for (int i = 0; i < 12; i++) begin
         fall_cmd(0, vecs[i].rt, vecs[i].l, vecs[i].r, vecs[i].t, "vec_model", lk, nw);
         chk_disp("vec_table", rows_mask(vecs[i].r0, vecs[i].r1, vecs[i].cm) | o_floor);
      end

      // Reset while a piece is falling.
      reset = 0;
      step();
      chk_disp("midreset_disp", '0);
      chk_int("midreset_score", score_o, 0);
      chk_int("midreset_gameover", gameover_o, 0);
      reset = 1;
      m_reset();
      step();

      // Five O pieces fill the bottom two rows.
      restart(1);
      for (int p = 0; p < 5; p++) begin
         int dx;
         dx = 2 * p - 4;
         for (int k = 0; k < (dx < 0 ? -dx : dx); k++)
            fall_cmd(0, 0, dx < 0, dx > 0, 0, "five_O_move", lk, nw);
         piece_i = 3'd1;
         fall_cmd(1, 0, 0, 0, 0, "five_O_drop", lk, nw);
         if (p == 4) begin
            chk_disp("two_lines_cleared", '0);
            chk_int("two_lines_score", score_o, 3);
            chk_int("two_lines_lines", lines_o, 2);
         end
         spawn_piece(1);
      end

      // Stack O pieces in the spawn column until the spawn collides.
      for (int p = 0; p < 10; p++) begin
         piece_i = 3'd1;
         fall_cmd(1, 0, 0, 0, 0, "stack_drop", lk, nw);
         spawn_piece(1);
      end
      chk_int("stack_gameover", gameover_o, 1);
      chk_disp("stack_held", rows_mask(0, 19, 10'b0000110000));
      chk_int("stack_score_held", score_o, 3);
      for (int k = 0; k < 3; k++) begin
         left_i = 1; tick_i = 1; drop_i = 1;
         step();
         chk_disp("gameover_frozen", rows_mask(0, 19, 10'b0000110000));
         chk_int("gameover_stays", gameover_o, 1);
      end
      restart(6);

      // Random play.
      for (int i = 0; i < 1500; i++) begin
         bit d, rt, l, r, t;
         int k, nextp;
         k = $urandom_range(0, 99);
         d  = (k < 4);
         rt = (k >= 4 && k < 20);
         l  = (k >= 20 && k < 35);
         r  = (k >= 35 && k < 50);
         t  = (k >= 50 && k < 75) || ($urandom_range(0, 4) == 0);
         nextp = $urandom_range(0, 6);
         piece_i = 3'(nextp);
         fall_cmd(d, rt, l, r, t, "rand_fall", lk, nw);
         if (lk) begin
            spawn_piece(nextp);
            if (m_go) restart($urandom_range(0, 6));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tetris_grid_engine.md
Name: tetris_grid_engine

Overview:
- Parametrised, single-clock Tetris playfield engine.
- Holds the locked-cell board and one active tetromino with 4 rotation states. Accepts pulse-style move, rotate, hard-drop and gravity-tick commands, checks every move for collision, clears full lines and keeps score.
- Sits between the input debouncers / gravity-tick divider / piece RNG and the VGA renderer.
- New relative to the previous engine: board size is a parameter, clocking is a single `clk` with a tick enable, rotation is collision-checked, and it adds hard drop, multi-line score weighting and restart.

Parameters:
ROWS, 20, board height in cells
COLS, 10, board width in cells (4..16)
SCORE_W, 16, score width
LINES_W, 10, lines-cleared counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tick_i  in  1  gravity strobe, 1-cycle pulse
start_i  in  1  start/restart pulse
left_i  in  1  move-left pulse
right_i  in  1  move-right pulse
rotate_i  in  1  rotate-clockwise pulse
drop_i  in  1  hard-drop pulse
piece_i  in  3  next piece type 0..6 (I,O,J,L,S,Z,T), sampled in SPAWN
piece_req_o  out  1  1-cycle pulse in SPAWN; RNG advances
display_o  out  ROWS*COLS  packed [ROWS-1:0][COLS-1:0]; row 0 is top
gameover_o  out  1  high in GAMEOVER
score_o  out  SCORE_W  saturating score
lines_o  out  LINES_W  saturating total lines cleared

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=IDLE; board, score, lines, pending_tick all 0.
  - All outputs 0.
  - Reset mid-operation aborts any state immediately.
- Active piece registers:
  - type, rot (2b), x (signed, $clog2(COLS)+2 bits), y ($clog2(ROWS)+1 bits).
  - 4x4 mask from tetromino_rom(type, rot). Mask cell (r,c) maps to board cell (y+r, x+c).
- fits(type, rot, x, y) is combinational. It is false if any set mask cell has col<0, col>=COLS or row>=ROWS, or overlaps a board cell.
- IDLE: start_i -> SPAWN.
- SPAWN (1 cycle):
  - piece_req_o=1; latch type=piece_i, rot=0, x=(COLS-4)/2, y=0; clear pending_tick.
  - Next state is FALL if the latched piece fits, else GAMEOVER. Spawn fit uses the piece_i value directly.
- FALL: at most one action per cycle, priority drop_i > rotate_i > left_i > right_i > gravity.
  - drop_i -> DROP.
  - rotate_i: rot <= rot+1 (mod 4) only if it fits; no wall kicks.
  - left_i / right_i: x -/+ 1 only if it fits. A rejected command is silently discarded.
  - Gravity fires when tick_i or pending_tick is set and no higher-priority input is present:
    - if fits at y+1: y <= y+1;
    - else -> LOCK.
    - Gravity clears pending_tick.
  - If tick_i arrives while a higher-priority input wins that cycle, set pending_tick; it is applied the next cycle.
- DROP: each cycle, y <= y+1 while fits at y+1; otherwise -> LOCK. Inputs are ignored.
- LOCK (1 cycle):
  - board |= active cells.
  - eval_row <= ROWS-1; clr_cnt <= 0; -> CLEAR.
- CLEAR, 1 row evaluated per cycle:
  - Full row: rows 1..eval_row take row-1, row 0 <= 0, clr_cnt++, eval_row unchanged (cascades).
  - Not full: if eval_row==0 -> SCORE, else eval_row--.
  - Worst case ROWS+4 cycles.
- SCORE (1 cycle):
  - score += {0,1,3,5,8}[clr_cnt]; lines += clr_cnt.
  - Both saturate at all-ones.
  - -> SPAWN.
- GAMEOVER:
  - gameover_o=1; board and score are held.
  - start_i clears board, score and lines, then -> SPAWN.
- display_o:
  - board | active cells while in FALL or DROP; board alone in all other states.
  - Combinational from registers, so zero latency after a state/position update.
- Move inputs in IDLE, SPAWN, LOCK, CLEAR and SCORE are ignored. They are not queued.

Decomposition:
- Package tetris_pkg:
  - state enum (IDLE, SPAWN, FALL, DROP, LOCK, CLEAR, SCORE, GAMEOVER);
  - piece_t enum (I,O,J,L,S,Z,T);
  - score weight table constant {0,1,3,5,8}.
- Sub-module tetromino_rom:
  - combinational (type, rot) -> 16-bit 4x4 mask.
  - O returns the same mask for all rotations.
  - I rot0 = row 1 cols 0..3; I rot1 = col 2 rows 0..3.

Test Plan:
- Reset, then start_i with piece_i=O -> piece_req_o 1 pulse; display_o rows 0-1, cols 4-5 set; score_o=0; gameover_o=0.
- I piece (rot0 row 1, cols 3..6), 4 left_i pulses -> cols 0..3 after the 3rd pulse; the 4th is rejected and x is unchanged. Then rotate_i -> vertical at col 2.
- Hard-drop O on an empty board -> lands on rows 18-19, cols 4-5 within 18 DROP cycles; LOCK writes the board; next SPAWN follows CLEAR+SCORE.
- Five O pieces hard-dropped at cols 0,2,4,6,8 -> rows 18-19 are full -> after CLEAR the board is empty, score_o=3, lines_o=2.
- tick_i and left_i in the same FALL cycle -> x decrements that cycle; y increments the next cycle (pending_tick).
- Hard-drop 10 O pieces at spawn -> cols 4-5 filled rows 0-19; 11th SPAWN fails -> gameover_o=1, display is held. start_i -> board is 0, score_o=0, a new piece spawns.
